// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
// State encodings, the reset value of the result, and the decode funct codes that drive start/signed_div.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE  = 2'b00,
      DIV_BUSY  = 2'b01,
      DIV_DZERO = 2'b10,
      DIV_DONE  = 2'b11
   } div_state_e;

   localparam logic [63:0] DIV_RESULT_ZERO = 64'b0;

   localparam logic [5:0] EXE_DIV  = 6'b011010;
   localparam logic [5:0] EXE_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step. This block is purely combinational.
// The divider instantiates it once and reuses it on every BUSY cycle.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             dividend_bit,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;

   // Both candidates fit in WIDTH bits because rem_in is always below the divisor.
   assign shifted_s = {rem_in, dividend_bit};
   assign diff_s    = shifted_s - {1'b0, divisor};
   assign q_bit     = (shifted_s >= {1'b0, divisor});
   assign rem_out   = q_bit ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit. It produces {remainder, quotient} for HI/LO and stalls the pipeline while it works.
// Optional macro DIV_BYZERO_FLAG_EN adds the div_zero output.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall
`ifdef DIV_BYZERO_FLAG_EN
   ,
   output logic               div_zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH);

   // The most negative value maps to 2^(WIDTH-1). Read as unsigned, that is exact.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      if (is_signed && v[WIDTH-1]) begin
         magnitude = {WIDTH{1'b0}} - v;
      end else begin
         magnitude = v;
      end
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      if (neg) begin
         apply_sign = {WIDTH{1'b0}} - v;
      end else begin
         apply_sign = v;
      end
   endfunction

   div_state_e         state_r, next_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   dvd_r;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   dvs_r;
   logic [WIDTH-1:0]   raw_dvd_r;
   logic               neg_q_r;
   logic               neg_rem_r;
   logic [2*WIDTH-1:0] result_r;
   logic               ready_r;
   logic               accept_s;
   logic               step_q_s;
   logic [WIDTH-1:0]   step_rem_s;
   logic [WIDTH-1:0]   final_q_s;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem_r),
      .divisor      (dvs_r),
      .dividend_bit (dvd_r[WIDTH-1]),
      .rem_out      (step_rem_s),
      .q_bit        (step_q_s)
   );

   // dvd_r doubles as the quotient register. Dividend bits shift out of the top, and quotient bits enter at the bottom.
   assign final_q_s = {dvd_r[WIDTH-2:0], step_q_s};

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state, stall and operand-accept decode
   always_comb begin
      next_s   = state_r;
      stall    = 1'b0;
      accept_s = 1'b0;
      case (state_r)
         DIV_IDLE: begin
            stall = start;
            if (start && !annul) begin
               accept_s = 1'b1;
               if (opdata2 == {WIDTH{1'b0}}) begin
                  next_s = DIV_DZERO;
               end else begin
                  next_s = DIV_BUSY;
               end
            end else begin
               next_s = DIV_IDLE;
            end
         end
         DIV_BUSY: begin
            stall = 1'b1;
            if (annul) begin
               next_s = DIV_IDLE;
            end else if (cnt_r == CNT_W'(WIDTH - 1)) begin
               next_s = DIV_DONE;
            end else begin
               next_s = DIV_BUSY;
            end
         end
         DIV_DZERO: begin
            stall = 1'b1;
            if (annul) begin
               next_s = DIV_IDLE;
            end else begin
               next_s = DIV_DONE;
            end
         end
         DIV_DONE: begin
            next_s = DIV_IDLE;
         end
         default: begin
            next_s = DIV_IDLE;
         end
      endcase
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r     <= {CNT_W{1'b0}};
         dvd_r     <= {WIDTH{1'b0}};
         rem_r     <= {WIDTH{1'b0}};
         dvs_r     <= {WIDTH{1'b0}};
         raw_dvd_r <= {WIDTH{1'b0}};
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         result_r  <= DIV_RESULT_ZERO[2*WIDTH-1:0];
         ready_r   <= 1'b0;
      end else begin
         ready_r <= (next_s == DIV_DONE);
         if (accept_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            dvd_r     <= magnitude(opdata1, signed_div);
            dvs_r     <= magnitude(opdata2, signed_div);
            rem_r     <= {WIDTH{1'b0}};
            raw_dvd_r <= opdata1;
            neg_q_r   <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_r <= signed_div & opdata1[WIDTH-1];
         end else if (state_r == DIV_BUSY && !annul) begin
            dvd_r <= final_q_s;
            rem_r <= step_rem_s;
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (state_r == DIV_BUSY && next_s == DIV_DONE) begin
            result_r <= {apply_sign(step_rem_s, neg_rem_r), apply_sign(final_q_s, neg_q_r)};
         end else if (state_r == DIV_DZERO && next_s == DIV_DONE) begin
            result_r <= {raw_dvd_r, {WIDTH{1'b1}}};
         end
      end
   end

`ifdef DIV_BYZERO_FLAG_EN
   logic div_zero_r;

   // Divide-by-zero flag, valid alongside the DONE cycle entered from DZERO
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_zero_r <= 1'b0;
      end else begin
         div_zero_r <= (state_r == DIV_DZERO) && (next_s == DIV_DONE);
      end
   end

   assign div_zero = div_zero_r;
`endif

   // A late annul still suppresses the completion pulse.
   assign result = result_r;
   assign ready  = ready_r & ~annul;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: signed/unsigned cases, divide by zero, annul, mid-operation reset, and ignored start.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stall;
`ifdef DIV_BYZERO_FLAG_EN
   logic        div_zero;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_res = 64'd0;

   always #5 clk = ~clk;

   div_unit dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .stall      (stall)
`ifdef DIV_BYZERO_FLAG_EN
      ,
      .div_zero   (div_zero)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launches one operation and watches up to 40 cycles after acceptance.
   // When annul_at is nonzero, annul is asserted in that cycle and no ready pulse may appear.
   // When junk_at is nonzero, a stray start with other operands is driven while the unit is busy.
   task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input int annul_at, input int junk_at);
      int          pulses;
      int          seen_lat;
      logic [63:0] got;
      logic        stall_ok;
      logic        dz_ok;
      logic        exp_stall;
      pulses   = 0;
      seen_lat = -1;
      got      = 64'd0;
      stall_ok = 1'b1;
      dz_ok    = 1'b1;
      @(negedge clk);
      start      = 1'b1;
      signed_div = sg;
      opdata1    = a;
      opdata2    = b;
      #1;
      chk({tag, "_stall_req"}, {63'd0, stall}, 64'd1);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         annul = (cyc == annul_at) ? 1'b1 : 1'b0;
         if (cyc == junk_at) begin
            start      = 1'b1;
            signed_div = 1'b0;
            opdata1    = 32'd50;
            opdata2    = 32'd5;
         end
         #1;
         if (annul_at != 0) begin
            exp_stall = (cyc <= annul_at);
         end else begin
            exp_stall = (cyc < lat);
         end
         if (stall !== exp_stall) stall_ok = 1'b0;
         if (ready === 1'b1) begin
            pulses++;
            if (seen_lat < 0) begin
               seen_lat = cyc;
               got      = result;
            end
         end
`ifdef DIV_BYZERO_FLAG_EN
         if (div_zero !== ((cyc == lat) && (b == 32'd0) && (annul_at == 0))) dz_ok = 1'b0;
`endif
      end
      annul = 1'b0;
      chk({tag, "_stall_window"}, {63'd0, stall_ok}, 64'd1);
      chk({tag, "_div_zero"}, {63'd0, dz_ok}, 64'd1);
      if (annul_at == 0) begin
         chk({tag, "_latency"}, 64'(seen_lat), 64'(lat));
         chk({tag, "_result"}, got, exp);
         chk({tag, "_pulses"}, 64'(pulses), 64'd1);
         last_res = exp;
      end else begin
         chk({tag, "_pulses"}, 64'(pulses), 64'd0);
         chk({tag, "_held"}, result, last_res);
      end
   endtask

   initial begin
      int pulses;
      resetn     = 1'b0;
      start      = 1'b0;
      signed_div = 1'b0;
      opdata1    = 32'd0;
      opdata2    = 32'd0;
      annul      = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_result", result, 64'd0);
      chk("reset_ready", {63'd0, ready}, 64'd0);
      chk("reset_stall", {63'd0, stall}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         33, 0, 0);
      run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   33, 0, 0);
      run_op("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   33, 0, 0);
      run_op("div_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000},   33, 0, 0);
      run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,          32'hFFFFFFFF},   33, 0, 0);
      run_op("divu_5_0",    1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFFFFFF},   2,  0, 0);
      run_op("div_m5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB,   32'hFFFFFFFF},   2,  0, 0);
      run_op("annul_20_4",  1'b0, 32'd20,         32'd4,          64'd0,                            33, 10, 0);
      run_op("divu_9_3",    1'b0, 32'd9,          32'd3,          {32'd0,          32'd3},          33, 0, 0);

      // Reset in the middle of an operation
      @(negedge clk);
      start      = 1'b1;
      signed_div = 1'b0;
      opdata1    = 32'd1000;
      opdata2    = 32'd10;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      resetn = 1'b0;
      #1;
      chk("midreset_result", result, 64'd0);
      chk("midreset_ready", {63'd0, ready}, 64'd0);
      chk("midreset_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      pulses = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         #1;
         if (ready === 1'b1) pulses++;
      end
      chk("midreset_no_ready", 64'(pulses), 64'd0);
      last_res = 64'd0;

      run_op("busy_start_ignored", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 0, 5);
      run_op("div_m100_7",  1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE,   32'hFFFFFFF2},   33, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
